// File: rtl/decision_pkg.sv
// Purpose: shared types and constants for the decision-tree job scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, response codes, class constants, small helpers.
package decision_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK        = 2'd0,
    RSP_TIMEOUT   = 2'd1,
    RSP_BAD_CLASS = 2'd2
  } rsp_code_t;

  localparam logic [7:0] Y1 = 8'd1;
  localparam logic [7:0] Y2 = 8'd2;
  localparam logic [7:0] Y3 = 8'd3;
  localparam logic [7:0] Y4 = 8'd4;

  // True for the four legal class results Y1..Y4.
  function automatic logic is_valid_class(input logic [7:0] y);
    return (y >= Y1) && (y <= Y4);
  endfunction

  // Histogram counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/decision_rr_arb.sv
// Purpose: 2-input round-robin arbiter; last winner drops to lowest priority.
// Latency: winner is combinational from req; priority updates on the clock after update.
// Backpressure: none; caller strobes update only when it accepts the winner.
// Ports: clk, reset_n (async active-low), req[1:0], update (accept strobe),
//        win[1:0] (one-hot winner, zero when no request).
module decision_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] win
);

  // prio names the requester that currently has highest priority.
  logic prio;

  always_comb begin
    win = 2'b00;
    if (!prio) begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end else begin
      if (req[1])      win = 2'b10;
      else if (req[0]) win = 2'b01;
    end
  end

  // After granting requester 0, requester 1 becomes highest, and vice versa.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= 1'b0;
    end else if (update && (|win)) begin
      prio <= win[0];
    end
  end

endmodule

// File: rtl/decision_sched.sv
// Purpose: arbitrates two job requesters onto one decision-tree datapath and returns class results.
// Latency: req_i to rsp_valid_o is 3+k cycles when the datapath answers k cycles after dt_start_o.
// Backpressure: response held stable in RESP until rsp_ready_i; new requests wait while busy.
// Ports: clk, reset_n; req_i/gnt_o requester handshake; dt_reset_o/dt_start_o/dt_y_i/dt_y_valid_i
//        datapath control; rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_y_o/rsp_code_o response;
//        busy_o; hist_y1_o..hist_y4_o/hist_err_o saturating result histograms.
module decision_sched
  import decision_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       dt_reset_o,
  output logic       dt_start_o,
  input  logic [7:0] dt_y_i,
  input  logic       dt_y_valid_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [7:0] rsp_y_o,
  output logic [1:0] rsp_code_o,
  output logic       busy_o,
  output logic [7:0] hist_y1_o,
  output logic [7:0] hist_y2_o,
  output logic [7:0] hist_y3_o,
  output logic [7:0] hist_y4_o,
  output logic [7:0] hist_err_o
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner;
  logic [7:0] timer;
  logic [1:0] win;
  logic       arb_update;

  // The arbiter pointer only moves when IDLE actually accepts a job.
  assign arb_update = (state == ST_IDLE) && (|req_i);

  decision_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_i),
    .update  (arb_update),
    .win     (win)
  );

  // Every output is registered: it is loaded on the edge that enters the state
  // that owns it, so it is valid for exactly the cycles spent in that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      timer       <= 8'd0;
      gnt_o       <= 2'b00;
      dt_reset_o  <= 1'b0;
      dt_start_o  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
      rsp_y_o     <= 8'd0;
      rsp_code_o  <= 2'd0;
      busy_o      <= 1'b0;
      hist_y1_o   <= 8'd0;
      hist_y2_o   <= 8'd0;
      hist_y3_o   <= 8'd0;
      hist_y4_o   <= 8'd0;
      hist_err_o  <= 8'd0;
    end else begin
      gnt_o      <= 2'b00;
      dt_reset_o <= 1'b0;
      dt_start_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|req_i) begin
            owner      <= win[1];
            gnt_o      <= win;
            dt_reset_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= ST_CLR;
          end
        end

        ST_CLR: begin
          dt_start_o <= 1'b1;
          state      <= ST_START;
        end

        ST_START: begin
          timer <= 8'd0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A result arriving on the expiry cycle is taken, not timed out.
          if (dt_y_valid_i) begin
            rsp_y_o     <= dt_y_i;
            rsp_code_o  <= is_valid_class(dt_y_i) ? RSP_OK : RSP_BAD_CLASS;
            rsp_id_o    <= owner;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else if (timer == TMAX) begin
            rsp_y_o     <= 8'd0;
            rsp_code_o  <= RSP_TIMEOUT;
            rsp_id_o    <= owner;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
            if (rsp_code_o == RSP_OK) begin
              case (rsp_y_o)
                Y1:      hist_y1_o <= sat_inc(hist_y1_o);
                Y2:      hist_y2_o <= sat_inc(hist_y2_o);
                Y3:      hist_y3_o <= sat_inc(hist_y3_o);
                Y4:      hist_y4_o <= sat_inc(hist_y4_o);
                default: ;
              endcase
            end else begin
              hist_err_o <= sat_inc(hist_err_o);
            end
          end
        end

        default: begin
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
